// File: rtl/ddr_cmd_arbiter_if.sv
// Bus bundle for ddr_cmd_arbiter: requester command/write-data ports, controller command port,
// read-data return path and status. The arbiter uses the slave view.
interface ddr_cmd_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int CMD_W     = 34,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 8
);
  localparam int CNTW = $clog2(TAG_DEPTH) + 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*CMD_W-1:0]  req_cmd;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [CMD_W-1:0]          command;
  logic                      valid;
  logic [DATA_W-1:0]         write_data;
  logic                      cmd_stall;
  logic [DATA_W-1:0]         read_data;
  logic                      read_data_valid;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [CNTW-1:0]           rd_outstanding;
  logic                      err_orphan;

  modport slave (
    input  req_valid, req_cmd, req_wdata, cmd_stall, read_data, read_data_valid,
    output req_ready, command, valid, write_data, rsp_valid, rsp_data, rd_outstanding, err_orphan
  );

  modport master (
    output req_valid, req_cmd, req_wdata, cmd_stall, read_data, read_data_valid,
    input  req_ready, command, valid, write_data, rsp_valid, rsp_data, rd_outstanding, err_orphan
  );
endinterface

// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter sharing the DDR controller command port among NUM_REQ requesters,
// with an in-order tag FIFO that steers returning read bursts back to their issuer.
module ddr_cmd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CMD_W     = 34,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 8
) (
  input  logic             clk,
  input  logic             power_on_rst_n,
  ddr_cmd_arbiter_if.slave bus
);
  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTRW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNTW = $clog2(TAG_DEPTH) + 1;

  logic                r_valid;
  logic [CMD_W-1:0]    r_cmd;
  logic [DATA_W-1:0]   r_wdata;
  logic [IDW-1:0]      r_id;
  logic [IDW-1:0]      r_rr_ptr;
  logic [IDW-1:0]      r_tag_mem [TAG_DEPTH];
  logic [PTRW-1:0]     r_wr_ptr;
  logic [PTRW-1:0]     r_rd_ptr;
  logic [CNTW-1:0]     r_count;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_err;

  logic                 w_accept;
  logic                 w_slot_free;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rd_room;
  logic                 w_found;
  logic [CNTW:0]        w_occ_next;
  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_grant;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [IDW:0]         w_off;
  logic [IDW:0]         w_sum;
  logic [IDW-1:0]       w_win;
  logic [IDW-1:0]       w_head;
  logic [CMD_W-1:0]     w_sel_cmd;
  logic [DATA_W-1:0]    w_sel_wdata;

  assign w_accept    = r_valid & ~bus.cmd_stall;
  assign w_slot_free = ~r_valid | w_accept;
  assign w_push      = w_accept & r_cmd[CMD_W-1];
  assign w_pop       = bus.read_data_valid & (r_count != '0);
  assign w_head      = r_tag_mem[r_rd_ptr];

  // A read may only be granted if the FIFO will still have room once this cycle's push/pop settle.
  assign w_occ_next = {1'b0, r_count} + {{CNTW{1'b0}}, w_push} - {{CNTW{1'b0}}, w_pop};
  assign w_rd_room  = (w_occ_next < (CNTW+1)'(TAG_DEPTH));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign w_elig[gi] = bus.req_valid[gi] & (~bus.req_cmd[gi*CMD_W + CMD_W - 1] | w_rd_room);
  end

  // Rotate so the search always starts at r_rr_ptr, then map the offset back to a requester ID.
  assign w_rot = {w_elig, w_elig} >> r_rr_ptr;

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        w_off   = (IDW+1)'(j);
      end
    end
  end

  assign w_sum = {1'b0, r_rr_ptr} + w_off;
  assign w_win = (w_sum >= (IDW+1)'(NUM_REQ)) ? IDW'(w_sum - (IDW+1)'(NUM_REQ)) : IDW'(w_sum);

  always_comb begin
    w_sel_cmd   = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_sel_cmd   = bus.req_cmd[i*CMD_W +: CMD_W];
        w_sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_grant       = (w_found && w_slot_free) ? (NUM_REQ'(1) << w_win) : '0;
  assign bus.req_ready = w_grant & {NUM_REQ{power_on_rst_n}};

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      r_valid  <= 1'b0;
      r_cmd    <= '0;
      r_wdata  <= '0;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else if (w_slot_free) begin
      if (w_found) begin
        r_valid  <= 1'b1;
        r_cmd    <= w_sel_cmd;
        r_wdata  <= w_sel_wdata;
        r_id     <= w_win;
        r_rr_ptr <= (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      end else begin
        r_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_occ_next[CNTW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= r_id;
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_pop ? (NUM_REQ'(1) << w_head) : '0;
      if (w_pop) r_rsp_data <= bus.read_data;
      if (bus.read_data_valid && (r_count == '0)) r_err <= 1'b1;
    end
  end

  assign bus.command        = r_cmd;
  assign bus.valid          = r_valid;
  assign bus.write_data     = r_wdata;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_data       = r_rsp_data;
  assign bus.rd_outstanding = r_count;
  assign bus.err_orphan     = r_err;
endmodule
